// File: rtl/slew_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : slew_pkg
//  Purpose  : Shared types and defaults for the slew_glide level smoother.
//             - slew_state_t : ramp direction state (IDLE / UP / DOWN)
//             - RATEW_DEFAULT: default width of the tick-period input
//  Revision : 1.0  initial release
// ============================================================================
package slew_pkg;

   // IDLE: output sits on the latched target; UP/DOWN: ramping toward it.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      UP   = 2'd1,
      DOWN = 2'd2
   } slew_state_t;

   localparam int RATEW_DEFAULT = 24;

endpackage : slew_pkg
`default_nettype wire

// File: rtl/tick_div.sv
`default_nettype none
// ============================================================================
//  Module   : tick_div
//  Purpose  : Programmable tick divider. Counts 0..rate while enabled and
//             raises tick for the cycle in which the count reaches rate,
//             then wraps to 0. Held at 0 while disabled or cleared.
//  Ports    : clk    - clock
//             rst    - synchronous active-high reset
//             clear  - restart the count from 0 at the next edge
//             enable - counter runs only when high
//             rate   - tick period minus one
//             tick   - combinational one-cycle tick strobe
//  Revision : 1.0  initial release
// ============================================================================
module tick_div
   import slew_pkg::*;
#(
   parameter int RATEW = RATEW_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             enable,
   input  logic [RATEW-1:0] rate,
   output logic             tick
);

   logic [RATEW-1:0] count;

   // ">=" rather than "==" so that lowering rate mid-ramp below the current
   // count fires at the next compare instead of running all the way round.
   assign tick = enable && (count >= rate);

   always_ff @(posedge clk) begin
      if (rst || clear || !enable) begin
         count <= '0;
      end else if (tick) begin
         count <= '0;
      end else begin
         count <= count + RATEW'(1);
      end
   end

endmodule : tick_div
`default_nettype wire

// File: rtl/slew_glide.sv
`default_nettype none
`ifndef BITS
`define BITS 16
`endif
// ============================================================================
//  Module   : slew_glide
//  Purpose  : Slew-rate limiter. When the target level changes, the output
//             ramps toward it by stepSize every rate+1 cycles, never
//             overshooting or wrapping. stepSize==0 jumps immediately.
//  Ports    : clk      - clock
//             rst      - synchronous active-high reset
//             target   - signed level to approach
//             rate     - tick period minus one
//             stepSize - unsigned per-tick step magnitude (0 = bypass)
//             sigOut   - registered slewed level
//             settled  - high while sigOut sits on the latched target
//             trig     - one-cycle pulse per detected target change
//  Revision : 1.0  initial release
// ============================================================================
module slew_glide
   import slew_pkg::*;
#(
   parameter int BITS  = `BITS,
   parameter int RATEW = RATEW_DEFAULT
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic signed [BITS-1:0] target,
   input  logic        [RATEW-1:0] rate,
   input  logic        [BITS-1:0] stepSize,
   output logic signed [BITS-1:0] sigOut,
   output logic                   settled,
   output logic                   trig
);

   slew_state_t             state, state_nxt;
   logic signed [BITS-1:0]  tgt_reg, tgt_nxt;
   logic signed [BITS-1:0]  sig_nxt;
   logic                    trig_nxt;

   logic                    change;
   logic                    tick;
   logic signed [BITS:0]    diff_up;
   logic signed [BITS:0]    diff_dn;
   logic signed [BITS:0]    step_ext;

   assign change   = (target != tgt_reg);
   assign diff_up  = {tgt_reg[BITS-1], tgt_reg} - {sigOut[BITS-1], sigOut};
   assign diff_dn  = {sigOut[BITS-1], sigOut} - {tgt_reg[BITS-1], tgt_reg};
   assign step_ext = {1'b0, stepSize};
   assign settled  = (state == IDLE);

   tick_div #(
      .RATEW (RATEW)
   ) u_tick_div (
      .clk    (clk),
      .rst    (rst),
      .clear  (change),
      .enable (state != IDLE),
      .rate   (rate),
      .tick   (tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         sigOut  <= '0;
         tgt_reg <= '0;
         trig    <= 1'b0;
      end else begin
         state   <= state_nxt;
         sigOut  <= sig_nxt;
         tgt_reg <= tgt_nxt;
         trig    <= trig_nxt;
      end
   end

   // A target change outranks a tick in the same cycle: the direction is
   // re-evaluated against the current output and the divider restarts.
   always_comb begin
      state_nxt = state;
      sig_nxt   = sigOut;
      tgt_nxt   = tgt_reg;
      trig_nxt  = 1'b0;
      if (change) begin
         tgt_nxt  = target;
         trig_nxt = 1'b1;
         if (stepSize == '0) begin
            sig_nxt   = target;
            state_nxt = IDLE;
         end else if (target == sigOut) begin
            state_nxt = IDLE;
         end else if (target > sigOut) begin
            state_nxt = UP;
         end else begin
            state_nxt = DOWN;
         end
      end else if (tick) begin
         // Distance is taken one bit wider so full-scale swings compare
         // correctly; the plain step below cannot overflow because it only
         // happens when the remaining distance exceeds stepSize.
         case (state)
            UP: begin
               if (diff_up <= step_ext) begin
                  sig_nxt   = tgt_reg;
                  state_nxt = IDLE;
               end else begin
                  sig_nxt = sigOut + $signed(stepSize);
               end
            end
            DOWN: begin
               if (diff_dn <= step_ext) begin
                  sig_nxt   = tgt_reg;
                  state_nxt = IDLE;
               end else begin
                  sig_nxt = sigOut - $signed(stepSize);
               end
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase
      end
   end

endmodule : slew_glide
`default_nettype wire

// File: tb/tb_slew_glide.sv
`default_nettype none
// ============================================================================
//  Module   : tb_slew_glide
//  Purpose  : Directed self-checking bench for slew_glide (BITS=16).
//  Revision : 1.0  initial release
// ============================================================================
module tb_slew_glide;

   localparam int BITS  = 16;
   localparam int RATEW = 24;

   logic                    clk = 1'b0;
   logic                    rst;
   logic signed [BITS-1:0]  target;
   logic        [RATEW-1:0] rate;
   logic        [BITS-1:0]  stepSize;
   logic signed [BITS-1:0]  sigOut;
   logic                    settled;
   logic                    trig;

   int total = 0;
   int bad   = 0;

   slew_glide #(
      .BITS  (BITS),
      .RATEW (RATEW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .target   (target),
      .rate     (rate),
      .stepSize (stepSize),
      .sigOut   (sigOut),
      .settled  (settled),
      .trig     (trig)
   );

   always #5 clk = ~clk;

   // Advance one active edge, then settle 1 time unit past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk3(input string tag, input int s, input int st, input int tr);
      chk({tag, ".sig"},     sigOut,  s);
      chk({tag, ".settled"}, settled, st);
      chk({tag, ".trig"},    trig,    tr);
   endtask

   initial begin
      // ---- reset with target 0 ----
      rst = 1'b1; target = '0; rate = 24'd3; stepSize = 16'd100;
      #1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk3("reset", 0, 1, 0);
      end
      rst = 1'b0;
      step();
      chk3("post_reset_idle", 0, 1, 0);

      // ---- 0 -> 1000, step 100, rate 3 ----
      target = 16'sd1000;
      step();
      chk3("up_change", 0, 0, 1);
      for (int i = 1; i <= 10; i++) begin
         repeat (3) step();
         chk("up_hold.sig", sigOut, 100 * (i - 1));
         step();
         chk("up_tick.sig", sigOut, 100 * i);
         chk("up_tick.trig", trig, 0);
      end
      chk("up_done.settled", settled, 1);

      // ---- 1000 -> -50, step 300, rate 0 ----
      rate = 24'd0; stepSize = 16'd300; target = -16'sd50;
      step();
      chk3("dn_change", 1000, 0, 1);
      step(); chk3("dn_1", 700, 0, 0);
      step(); chk3("dn_2", 400, 0, 0);
      step(); chk3("dn_3", 100, 0, 0);
      step(); chk3("dn_4", -50, 1, 0);

      // ---- bypass jump back to 0 ----
      stepSize = 16'd0; target = 16'sd0;
      step();
      chk3("bypass_zero", 0, 1, 1);

      // ---- retarget mid-ramp, change wins over a coincident tick ----
      stepSize = 16'd100; rate = 24'd1; target = 16'sd1000;
      step();                       // change edge, counter 0
      chk3("rt_change", 0, 0, 1);
      repeat (10) step();           // ticks every 2 edges -> 500
      chk("rt_at500.sig", sigOut, 500);
      step();                       // counter now at rate: tick pending
      chk("rt_pre.sig", sigOut, 500);
      target = 16'sd200;
      step();                       // change beats tick: no step to 600
      chk3("rt_retarget", 500, 0, 1);
      step(); chk3("rt_wait", 500, 0, 0);
      step(); chk3("rt_1", 400, 0, 0);
      step(); chk("rt_1h.sig", sigOut, 400);
      step(); chk3("rt_2", 300, 0, 0);
      step(); chk("rt_2h.sig", sigOut, 300);
      step(); chk3("rt_3", 200, 1, 0);
      step(); chk3("rt_hold", 200, 1, 0);

      // ---- full-scale bypass jumps, no wrap ----
      stepSize = 16'd0; target = -16'sd32768;
      step();
      chk3("fs_min", -32768, 1, 1);
      target = 16'sd32767;
      step();
      chk3("fs_max", 32767, 1, 1);
      step();
      chk3("fs_after", 32767, 1, 0);

      // ---- reset mid-ramp at 600 ----
      target = 16'sd500;
      step();
      chk("mr_pre.sig", sigOut, 500);
      stepSize = 16'd100; rate = 24'd0; target = 16'sd1000;
      step();
      chk3("mr_change", 500, 0, 1);
      step();
      chk("mr_600.sig", sigOut, 600);
      rst = 1'b1;
      step();
      chk3("mr_reset", 0, 1, 0);
      step();
      chk3("mr_reset2", 0, 1, 0);
      rst = 1'b0;
      step();
      chk3("mr_fresh", 0, 0, 1);
      step();
      chk3("mr_fresh_1", 100, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_slew_glide
`default_nettype wire

// File: doc/slew_glide.md
SLEW_GLIDE -- requirements
Module: slew_glide

Interface
REQ-001 Parameter BITS, default `BITS (16 in benches), sample width of all signed level ports.
REQ-002 Parameter RATEW, default 24, width of rate input.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 target  input  signed [BITS-1:0]  level to approach; driven directly by the upstream step sequencer's sigOut.
REQ-006 rate  input  unsigned [RATEW-1:0]  tick period minus 1; one slew step applied every rate+1 cycles.
REQ-007 stepSize  input  unsigned [BITS-1:0]  magnitude added/subtracted per tick; 0 = bypass (instant jump).
REQ-008 sigOut  output reg  signed [BITS-1:0]  slewed level.
REQ-009 settled  output  1  high when sigOut equals the latched target.
REQ-010 trig  output reg  1  one-cycle pulse per detected target change.

Function
REQ-011 Block SHALL hold registered copy tgtReg; change event when target != tgtReg at a clock edge.
REQ-012 On change event at edge k: tgtReg<=target, trig<=1 (high for cycle after k only), tick counter<=0, state selected from target vs current sigOut.
REQ-013 States SHALL be IDLE, UP, DOWN; IDLE when target==sigOut, UP when target>sigOut, DOWN when target<sigOut.
REQ-014 Tick counter SHALL count 0..rate, assert tick when counter==rate, then wrap to 0; runs only in UP/DOWN, held at 0 in IDLE.
REQ-015 First slew step after change at edge k SHALL occur at edge k+rate+1.
REQ-016 On tick in UP: diff=tgtReg-sigOut computed in BITS+1 bits; if diff<=stepSize then sigOut<=tgtReg, state<=IDLE, else sigOut<=sigOut+stepSize.
REQ-017 On tick in DOWN: symmetric with diff=sigOut-tgtReg and subtraction.
REQ-018 sigOut SHALL never pass tgtReg and never wrap; all intermediate sums at BITS+1 bits.
REQ-019 stepSize==0: on change event at edge k, sigOut<=target at edge k, state IDLE, trig still pulses.
REQ-020 Retarget mid-ramp: change event takes priority over tick in same cycle; direction recomputed from current sigOut; counter restarts.
REQ-021 rate/stepSize changes mid-ramp SHALL take effect at next counter compare/tick without restarting.
REQ-022 settled SHALL be combinational (state==IDLE).

Reset
REQ-023 rst high at an edge SHALL force sigOut=0, tgtReg=0, counter=0, state=IDLE, trig=0; overrides all other events including a change event.
REQ-024 After rst release with target!=0, first edge SHALL register a change event per REQ-012.

Structure
REQ-025 Package slew_pkg SHALL hold state enum (IDLE/UP/DOWN) and default RATEW.
REQ-026 Tick counter SHALL be sub-module tick_div (inputs clk, rst, clear, enable, rate; output tick).

Verification
REQ-027 Reset with target=0 -> sigOut=0, settled=1, trig=0 every cycle.
REQ-028 target 0->1000, stepSize=100, rate=3 -> trig one pulse; sigOut +100 every 4 cycles; 1000 after 40 cycles; settled=1.
REQ-029 target 1000->-50, stepSize=300, rate=0 -> sigOut 700,400,100,-50 on consecutive edges, then settled.
REQ-030 Ramping to 1000 at sigOut=500, target->200 -> second trig, state DOWN, sigOut 400,300,200 per tick, no overshoot.
REQ-031 stepSize=0, target -32768->32767 -> sigOut=32767 at change edge, trig pulse, no wrap.
REQ-032 rst asserted mid-ramp at sigOut=600 -> next edge sigOut=0, trig=0; after release target=1000 -> fresh change event.
